shift_add_mult_ctrl: RTL and testbench

Sequential shift-and-add controller for the 4x4 multiplier. It sits directly upstream of the 8-bit ripple-carry adder. Each cycle it drives one partial-product addition into that adder and registers the returned sum, accumulating an 8-bit product over a fixed number of cycles. Operands enter and the product leaves through valid/ready handshakes.

---
 rtl/shift_add_mult_ctrl_if.sv | 23 ++
 rtl/shift_add_mult_ctrl.sv | 118 +++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_mult_ctrl_if.sv
// Operand/product handshake bundle for the shift-and-add multiplier controller.
// master: producer of operands and consumer of products; slave: the controller.
interface shift_add_mult_ctrl_if #(
    parameter int OPW = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [OPW-1:0]     in_a;
    logic [OPW-1:0]     in_b;
    logic               out_valid;
    logic               out_ready;
    logic [2*OPW-1:0]   out_p;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Shift-and-add controller for the OPW x OPW multiplier. Each ADD cycle drives one
// partial product into the external 2*OPW-bit adder and captures the returned sum.
// Optional feature macro: MULT_SIGNED_EN (two's complement operands; the last step
// subtracts the weighted multiplicand instead of adding it).
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// ADD   | one partial-product addition per cycle, step 0..OPW-1
// DONE  | product presented, out_valid=1 until out_ready
module shift_add_mult_ctrl #(
    parameter int OPW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_add_mult_ctrl_if.slave bus,
    output logic [2*OPW-1:0]     add_a,
    output logic [2*OPW-1:0]     add_b,
    output logic                 add_cin,
    input  logic [2*OPW-1:0]     add_s,
    input  logic                 add_cout,
    output logic                 add_fault
);
    localparam int PW = 2 * OPW;
    localparam int IW = (OPW > 1) ? $clog2(OPW) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   mcand;
    logic [OPW-1:0]  mult;
    logic [IW-1:0]   step;
    logic            last_step;
    logic            accept;
    logic [PW-1:0]   mcand_ext;
    logic [PW-1:0]   mcand_sh;

    assign last_step = (step == IW'(OPW - 1));
    assign accept    = bus.in_valid && (state == IDLE);
    assign mcand_sh  = mcand << step;
    assign bus.out_p = acc;

`ifdef MULT_SIGNED_EN
    assign mcand_ext = {{OPW{bus.in_a[OPW-1]}}, bus.in_a};
`else
    assign mcand_ext = {{OPW{1'b0}}, bus.in_a};
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and adder/handshake drive; adder inputs are zero outside ADD
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        add_a         = '0;
        add_b         = '0;
        add_cin       = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = ADD;
            end
            ADD: begin
                add_a = acc;
                if (mult[step]) add_b = mcand_sh;
`ifdef MULT_SIGNED_EN
                // Sign bit of the multiplier carries negative weight: add ~x + 1.
                if (last_step && mult[step]) begin
                    add_b   = ~mcand_sh;
                    add_cin = 1'b1;
                end
`endif
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, accumulator and step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
            mult  <= '0;
            step  <= '0;
        end else if (accept) begin
            acc   <= '0;
            mcand <= mcand_ext;
            mult  <= bus.in_b;
            step  <= '0;
        end else if (state == ADD) begin
            acc   <= add_s;
            step  <= step + 1'b1;
        end
    end

    // Sticky carry-out fault; a carry is legitimate in signed mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_fault <= 1'b0;
        end else begin
`ifdef MULT_SIGNED_EN
            add_fault <= 1'b0;
`else
            if ((state == ADD) && add_cout) add_fault <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl with a behavioural adder and product model.
// Honours MULT_SIGNED_EN the same way the design does.
module tb_shift_add_mult_ctrl;
    localparam int OPW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] add_a, add_b, add_s;
    logic       add_cin, add_cout, add_fault;
    logic       force_cout = 1'b0;
    logic [8:0] sum9;

    shift_add_mult_ctrl_if #(.OPW(OPW)) bus();

    shift_add_mult_ctrl #(.OPW(OPW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .add_fault (add_fault)
    );

    always #5 clk = ~clk;

    // external ripple-carry adder stand-in
    assign sum9     = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
    assign add_s    = sum9[7:0];
    assign add_cout = sum9[8] | force_cout;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] p;
        int         t;
    } exp_t;
    exp_t sb[$];

    logic       act = 1'b0;
    int         act_t = 0;
    logic [3:0] act_a = '0;
    logic [3:0] act_b = '0;
    logic [7:0] run_acc = '0;
    logic [8:0] pp;
    int         k;
    logic       prev_ov = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    function automatic int sval(input logic [3:0] v);
`ifdef MULT_SIGNED_EN
        return v[3] ? int'(v) - 16 : int'(v);
`else
        return int'(v);
`endif
    endfunction

    function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b);
        int prod;
        prod = sval(a) * sval(b);
        return prod[7:0];
    endfunction

    // expected {cin, add_b} for ADD step kk
    function automatic logic [8:0] partial(input logic [3:0] a, input logic [3:0] b, input int kk);
        logic [7:0] m;
        int         w;
        w = sval(a) * (1 << kk);
        m = w[7:0];
`ifdef MULT_SIGNED_EN
        if (kk == 3) return b[3] ? {1'b1, ~m} : 9'd0;
`endif
        return b[kk] ? {1'b0, m} : 9'd0;
    endfunction

    // monitor: adder drive per cycle, latency and product against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_ov = 1'b0;
        end else begin
            k = cyc - act_t;
            if (act && k >= 0 && k < 4) begin
                if (k == 0) run_acc = 8'h00;
                pp = partial(act_a, act_b, k);
                chk("add_a", add_a, run_acc);
                chk("add_b", add_b, pp[7:0]);
                chk("add_cin", add_cin, pp[8]);
                run_acc = run_acc + pp[7:0] + {7'd0, pp[8]};
            end else begin
                chk("adder_idle", {add_a, add_b, add_cin}, 17'd0);
            end
            if (bus.out_valid && !prev_ov) begin
                if (sb.size() == 0) fail_now("spurious_out_valid");
                else chk("latency", cyc - sb[0].t, 4);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) fail_now("unexpected_product");
                else begin
                    chk("out_p", bus.out_p, sb[0].p);
                    void'(sb.pop_front());
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            fail_now("in_ready_timeout");
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk); #1;
        sb.push_back('{p: model(a, b), t: cyc});
        act_t = cyc;
        act_a = a;
        act_b = b;
        act   = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_a     = 4'($urandom);
        bus.in_b     = 4'($urandom);
    endtask

    task automatic finish_txn(input logic [7:0] want, input int hold);
        int n = 0;
        bus.out_ready = (hold == 0);
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.out_valid) begin
            fail_now("out_valid_timeout");
            bus.out_ready = 1'b1;
            return;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_out_p", bus.out_p, want);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("out_valid_drop", bus.out_valid, 0);
        chk("in_ready_back", bus.in_ready, 1);
    endtask

    task automatic do_txn(input logic [3:0] a, input logic [3:0] b, input int hold);
        if (hold > 0) bus.out_ready = 1'b0;
        send(a, b);
        finish_txn(model(a, b), hold);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_p", bus.out_p, 0);
        chk("rst_add_fault", add_fault, 0);
        chk("rst_adder", {add_a, add_b, add_cin}, 17'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef MULT_SIGNED_EN
        do_txn(4'hD, 4'h5, 0);
        chk("model_neg3x5", model(4'hD, 4'h5), 8'hF1);
        do_txn(4'h8, 4'h8, 0);
        do_txn(4'h7, 4'hF, 0);
        do_txn(4'h9, 4'hA, 3);
`else
        do_txn(4'd13, 4'd11, 0);
        do_txn(4'd15, 4'd15, 0);
        chk("no_fault_max", add_fault, 0);
        do_txn(4'd9, 4'd0, 0);
        do_txn(4'd0, 4'd7, 0);
        do_txn(4'd13, 4'd11, 3);
`endif

        for (int r = 0; r < 24; r++) begin
            do_txn(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
        end
        chk("no_fault_random", add_fault, 0);

`ifndef MULT_SIGNED_EN
        // carry-out injected on step 2 must latch the fault
        send(4'd15, 4'd15);
        @(posedge clk); #1;
        @(posedge clk); #1;
        force_cout = 1'b1;
        @(posedge clk); #1;
        force_cout = 1'b0;
        chk("fault_set", add_fault, 1);
        finish_txn(model(4'd15, 4'd15), 0);
        do_txn(4'd3, 4'd4, 0);
        chk("fault_sticky", add_fault, 1);
`endif

        // reset during ADD step 1 aborts the transaction
        send(4'd5, 4'd9);
        @(posedge clk); #1;
        rst_n = 1'b0;
        act   = 1'b0;
        #1;
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_fault_clr", add_fault, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_txn(4'd6, 4'd6, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
